// File: rtl/led_remote_pkg.sv
// Shared definitions for the LED remote brightness control block:
// debouncer state encoding, level width/limits, repeat FSM states.
package led_remote_pkg;

   localparam logic [1:0] BTN_IDLE     = 2'd0;
   localparam logic [1:0] BTN_DEBOUNCE = 2'd1;
   localparam logic [1:0] BTN_PRESS    = 2'd2;
   localparam logic [1:0] BTN_HELD     = 2'd3;

   localparam int unsigned LEVEL_W = 4;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

   // Last phase value of the 15-step PWM period.
   localparam logic [LEVEL_W-1:0] PHASE_LAST = 4'd14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD_UP,
      ST_RPT_UP,
      ST_HOLD_DN,
      ST_RPT_DN
   } rpt_state_t;

   // A button counts as "still down" while it is pressed or held.
   function automatic logic btn_active(input logic [1:0] s);
      return (s == BTN_PRESS) || (s == BTN_HELD);
   endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// 15-step PWM generator: prescaler, phase counter, shadowed duty level
// and registered LED drive. The shadow level only reloads when the phase
// wraps 14->0, so a level change never produces a glitched period.
module led_pwm_gen
   import led_remote_pkg::*;
#(
   parameter int unsigned PWM_DIV    = 1000,
   parameter int unsigned INIT_LEVEL = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LEVEL_W-1:0] level,
   output logic               led
);

   localparam logic [31:0]        PRESCALE_LAST = 32'(PWM_DIV - 1);
   localparam logic [LEVEL_W-1:0] INIT_VAL      = LEVEL_W'(INIT_LEVEL);

   logic [31:0]        prescale;
   logic [LEVEL_W-1:0] phase;
   logic [LEVEL_W-1:0] shadow_level;

   // Prescaler steps the phase; the shadow level reloads at the period boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescale     <= '0;
         phase        <= '0;
         shadow_level <= INIT_VAL;
         led          <= 1'b0;
      end else begin
         led <= (shadow_level > phase);
         if (prescale == PRESCALE_LAST) begin
            prescale <= '0;
            if (phase == PHASE_LAST) begin
               phase        <= '0;
               shadow_level <= level;
            end else begin
               phase <= phase + LEVEL_W'(1);
            end
         end else begin
            prescale <= prescale + 32'd1;
         end
      end
   end

endmodule

// File: rtl/led_level_pwm.sv
// LED brightness controller: up/down button press events adjust a 4-bit
// saturating level that drives a 15-step PWM output.
// Optional feature macro LED_AUTO_REPEAT_EN adds a hold/auto-repeat FSM
// that keeps stepping the level while a button stays held.
module led_level_pwm
   import led_remote_pkg::*;
#(
   parameter int unsigned INIT_LEVEL = 8,
   parameter int unsigned PWM_DIV    = 1000,
   parameter int unsigned HOLD_D     = 25000000,
   parameter int unsigned REPEAT_D   = 5000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         up_s,
   input  logic [1:0]         down_s,
   output logic [LEVEL_W-1:0] level,
   output logic               led,
   output logic               step
);

   localparam logic [LEVEL_W-1:0] INIT_VAL = LEVEL_W'(INIT_LEVEL);

   logic up_prev;
   logic down_prev;
   logic up_evt;
   logic down_evt;
   logic inc_req;
   logic dec_req;

   // Remember whether each button was in the press state last cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         up_prev   <= 1'b0;
         down_prev <= 1'b0;
      end else begin
         up_prev   <= (up_s == BTN_PRESS);
         down_prev <= (down_s == BTN_PRESS);
      end
   end

   // A press event is the first cycle a button reports the press state.
   always_comb begin
      up_evt   = (up_s == BTN_PRESS) && !up_prev;
      down_evt = (down_s == BTN_PRESS) && !down_prev;
   end

`ifdef LED_AUTO_REPEAT_EN

   localparam logic [31:0] HOLD_LAST = 32'(HOLD_D - 1);
   localparam logic [31:0] RPT_LAST  = 32'(REPEAT_D - 1);

   rpt_state_t  state;
   rpt_state_t  state_next;
   logic [31:0] rpt_cnt;
   logic        cnt_clear;
   logic        rpt_up;
   logic        rpt_dn;

   // Repeat FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Cycle counter for hold/repeat timing; saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_cnt <= '0;
      end else if (cnt_clear) begin
         rpt_cnt <= '0;
      end else if (rpt_cnt != '1) begin
         rpt_cnt <= rpt_cnt + 32'd1;
      end
   end

   // Next-state and repeat-step decode; the other button's press aborts a hold.
   always_comb begin
      state_next = state;
      cnt_clear  = 1'b0;
      rpt_up     = 1'b0;
      rpt_dn     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (up_evt && down_evt) begin
               state_next = ST_IDLE;
            end else if (up_evt) begin
               state_next = ST_HOLD_UP;
            end else if (down_evt) begin
               state_next = ST_HOLD_DN;
            end
         end
         ST_HOLD_UP, ST_RPT_UP: begin
            if (down_evt) begin
               state_next = ST_IDLE;
            end else if (up_evt) begin
               state_next = ST_HOLD_UP;
               cnt_clear  = 1'b1;
            end else if (!btn_active(up_s)) begin
               state_next = ST_IDLE;
            end else if (up_s == BTN_HELD) begin
               if (state == ST_HOLD_UP && rpt_cnt >= HOLD_LAST) begin
                  rpt_up     = 1'b1;
                  state_next = ST_RPT_UP;
               end else if (state == ST_RPT_UP && rpt_cnt >= RPT_LAST) begin
                  rpt_up    = 1'b1;
                  cnt_clear = 1'b1;
               end
            end
         end
         ST_HOLD_DN, ST_RPT_DN: begin
            if (up_evt) begin
               state_next = ST_IDLE;
            end else if (down_evt) begin
               state_next = ST_HOLD_DN;
               cnt_clear  = 1'b1;
            end else if (!btn_active(down_s)) begin
               state_next = ST_IDLE;
            end else if (down_s == BTN_HELD) begin
               if (state == ST_HOLD_DN && rpt_cnt >= HOLD_LAST) begin
                  rpt_dn     = 1'b1;
                  state_next = ST_RPT_DN;
               end else if (state == ST_RPT_DN && rpt_cnt >= RPT_LAST) begin
                  rpt_dn    = 1'b1;
                  cnt_clear = 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (state_next != state) begin
         cnt_clear = 1'b1;
      end
   end

   // Level change requests come from press events and repeat steps.
   always_comb begin
      inc_req = up_evt | rpt_up;
      dec_req = down_evt | rpt_dn;
   end

`else

   // Only single press events change the level in this build.
   always_comb begin
      inc_req = up_evt;
      dec_req = down_evt;
   end

`endif

   // Saturating level update; step pulses only when the level really moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= INIT_VAL;
         step  <= 1'b0;
      end else begin
         step <= 1'b0;
         if (inc_req && !dec_req && level != LEVEL_MAX) begin
            level <= level + LEVEL_W'(1);
            step  <= 1'b1;
         end else if (dec_req && !inc_req && level != '0) begin
            level <= level - LEVEL_W'(1);
            step  <= 1'b1;
         end
      end
   end

   led_pwm_gen #(
      .PWM_DIV    (PWM_DIV),
      .INIT_LEVEL (INIT_LEVEL)
   ) u_pwm (
      .clk   (clk),
      .rst   (rst),
      .level (level),
      .led   (led)
   );

endmodule

// File: tb/tb_led_level_pwm.sv
// Scoreboard testbench for led_level_pwm. A behavioural model predicts
// level/step/led for every cycle; a monitor compares at the falling edge.
module tb_led_level_pwm;

   localparam int INIT_LEVEL = 8;
   localparam int PWM_DIV    = 2;
   localparam int HOLD_D     = 20;
   localparam int REPEAT_D   = 5;
   localparam int PERIOD     = PWM_DIV * 15;

`ifdef LED_AUTO_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] up_s = 2'd0;
   logic [1:0] down_s = 2'd0;
   logic [3:0] level;
   logic       led;
   logic       step;

   led_level_pwm #(
      .INIT_LEVEL (INIT_LEVEL),
      .PWM_DIV    (PWM_DIV),
      .HOLD_D     (HOLD_D),
      .REPEAT_D   (REPEAT_D)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .up_s   (up_s),
      .down_s (down_s),
      .level  (level),
      .led    (led),
      .step   (step)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int lvl;
      int stp;
      int ld;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   edge_count = 0;
   int   errors = 0;
   int   checks = 0;

   // Model state: level, press history, active hold session, PWM time base.
   int m_lvl = INIT_LEVEL;
   bit m_prev_u = 1'b0;
   bit m_prev_d = 1'b0;
   int m_sess = 0;
   int m_start = 0;
   int m_cyc = 0;
   int m_j = 0;
   int m_shadow = INIT_LEVEL;

   // Count rising edges so expectations can be matched to the edge they follow.
   always @(posedge clk) edge_count <= edge_count + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Predict the outputs after the coming edge from this cycle's inputs.
   task automatic modelStep(input int u, input int d, input bit r);
      exp_t e;
      bit up_ev, dn_ev, rpt_u, rpt_d, inc, dec;
      int act, held_for, stp, ld;
      stp = 0;
      ld  = 0;
      if (r) begin
         m_lvl    = INIT_LEVEL;
         m_prev_u = 1'b0;
         m_prev_d = 1'b0;
         m_sess   = 0;
         m_j      = 0;
         m_shadow = INIT_LEVEL;
      end else begin
         up_ev = (u == 2) && !m_prev_u;
         dn_ev = (d == 2) && !m_prev_d;
         ld = (m_shadow > ((m_j / PWM_DIV) % 15)) ? 1 : 0;
         if (m_j % PERIOD == PERIOD - 1) m_shadow = m_lvl;
         rpt_u = 1'b0;
         rpt_d = 1'b0;
         if (RPT_EN) begin
            act      = m_sess;
            held_for = m_cyc - m_start;
            if (!up_ev && !dn_ev && held_for >= HOLD_D && (held_for - HOLD_D) % REPEAT_D == 0) begin
               if (act == 1 && u == 3) rpt_u = 1'b1;
               if (act == 2 && d == 3) rpt_d = 1'b1;
            end
            if (up_ev && dn_ev) m_sess = 0;
            else if (up_ev) begin
               if (act == 2) m_sess = 0;
               else begin m_sess = 1; m_start = m_cyc; end
            end else if (dn_ev) begin
               if (act == 1) m_sess = 0;
               else begin m_sess = 2; m_start = m_cyc; end
            end else if (act == 1 && !(u == 2 || u == 3)) m_sess = 0;
            else if (act == 2 && !(d == 2 || d == 3)) m_sess = 0;
         end
         inc = up_ev || rpt_u;
         dec = dn_ev || rpt_d;
         if (inc && !dec && m_lvl < 15) begin m_lvl++; stp = 1; end
         else if (dec && !inc && m_lvl > 0) begin m_lvl--; stp = 1; end
         m_prev_u = (u == 2);
         m_prev_d = (d == 2);
         m_j++;
      end
      m_cyc++;
      e.cyc = edge_count + 1;
      e.lvl = m_lvl;
      e.stp = stp;
      e.ld  = ld;
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs, queue its expectation, return just after the edge.
   task automatic applyStimulus(input int u, input int d, input bit r);
      up_s   = 2'(u);
      down_s = 2'(d);
      rst    = r;
      modelStep(u, d, r);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b0);
   endtask

   task automatic pressUp();
      applyStimulus(1, 0, 1'b0);
      applyStimulus(2, 0, 1'b0);
      applyStimulus(0, 0, 1'b0);
   endtask

   task automatic pressDown();
      applyStimulus(0, 1, 1'b0);
      applyStimulus(0, 2, 1'b0);
      applyStimulus(0, 0, 1'b0);
   endtask

   function automatic int nextBtn(input int cur);
      case (cur)
         0: return ($urandom_range(0, 3) == 0) ? 1 : 0;
         1: return $urandom_range(0, 2);
         2: return ($urandom_range(0, 1) == 0) ? 3 : 0;
         default: return ($urandom_range(0, 29) == 0) ? 0 : 3;
      endcase
   endfunction

   // Monitor: compare every expectation belonging to the edge just passed.
   initial begin
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc == edge_count) begin
            mon_e = sb_q.pop_front();
            checkOutput("level", level, mon_e.lvl);
            checkOutput("step", step, mon_e.stp);
            checkOutput("led", led, mon_e.ld);
         end
      end
   end

   // Safety net so the run always terminates.
   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int highs;
      int ru, rd;

      $display("[TB] reset");
      applyStimulus(0, 0, 1'b1);
      applyStimulus(0, 0, 1'b1);
      checkOutput("reset_level", level, INIT_LEVEL);
      checkOutput("reset_led", led, 0);
      checkOutput("reset_step", step, 0);

      $display("[TB] single up press from reset level");
      applyStimulus(0, 0, 1'b0);
      applyStimulus(1, 0, 1'b0);
      applyStimulus(2, 0, 1'b0);
      checkOutput("press_level", level, 9);
      checkOutput("press_step", step, 1);
      applyStimulus(3, 0, 1'b0);
      checkOutput("press_step_once", step, 0);
      applyStimulus(0, 0, 1'b0);
      idle(3);

      $display("[TB] PWM duty at level 5");
      while (m_lvl > 5) pressDown();
      idle(62);
      highs = 0;
      for (int i = 0; i < PERIOD; i++) begin
         applyStimulus(0, 0, 1'b0);
         if (led) highs++;
      end
      checkOutput("duty5_high_cycles", highs, 10);
      idle(7);
      while (m_lvl < 10) pressUp();
      idle(70);

      $display("[TB] saturation at both ends");
      while (m_lvl < 15) pressUp();
      applyStimulus(1, 0, 1'b0);
      applyStimulus(2, 0, 1'b0);
      checkOutput("sat_hi_level", level, 15);
      checkOutput("sat_hi_step", step, 0);
      applyStimulus(0, 0, 1'b0);
      while (m_lvl > 0) pressDown();
      applyStimulus(0, 1, 1'b0);
      applyStimulus(0, 2, 1'b0);
      checkOutput("sat_lo_level", level, 0);
      checkOutput("sat_lo_step", step, 0);
      applyStimulus(0, 0, 1'b0);

      $display("[TB] simultaneous presses");
      while (m_lvl < 5) pressUp();
      applyStimulus(1, 1, 1'b0);
      applyStimulus(2, 2, 1'b0);
      checkOutput("both_level", level, 5);
      checkOutput("both_step", step, 0);
      for (int i = 0; i < 25; i++) applyStimulus(3, 3, 1'b0);
      checkOutput("both_held_level", level, 5);
      applyStimulus(0, 0, 1'b0);
      idle(2);

      $display("[TB] held up button");
      while (m_lvl > 2) pressDown();
      applyStimulus(1, 0, 1'b0);
      applyStimulus(2, 0, 1'b0);
      for (int i = 0; i < 39; i++) applyStimulus(3, 0, 1'b0);
      applyStimulus(0, 0, 1'b0);
      checkOutput("hold_level", level, RPT_EN ? 7 : 3);
      idle(10);
      checkOutput("hold_release_level", level, RPT_EN ? 7 : 3);

      $display("[TB] reset during repeat");
      while (m_lvl < 10) pressUp();
      applyStimulus(1, 0, 1'b0);
      applyStimulus(2, 0, 1'b0);
      for (int i = 0; i < 22; i++) applyStimulus(3, 0, 1'b0);
      checkOutput("pre_reset_level", level, RPT_EN ? 12 : 11);
      applyStimulus(3, 0, 1'b1);
      applyStimulus(3, 0, 1'b1);
      checkOutput("mid_reset_level", level, INIT_LEVEL);
      checkOutput("mid_reset_led", led, 0);
      for (int i = 0; i < 30; i++) applyStimulus(3, 0, 1'b0);
      checkOutput("post_reset_level", level, INIT_LEVEL);
      applyStimulus(0, 0, 1'b0);
      pressUp();

      $display("[TB] randomized button activity");
      ru = 0;
      rd = 0;
      for (int i = 0; i < 450; i++) begin
         ru = nextBtn(ru);
         rd = nextBtn(rd);
         if ($urandom_range(0, 199) == 0) begin
            applyStimulus(ru, rd, 1'b1);
         end else begin
            applyStimulus(ru, rd, 1'b0);
         end
      end
      idle(3);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
